fir_addr_sequencer: RTL and testbench
=====================================

// Module: fir_addr_sequencer
// PURPOSE
//  Parametrised address/control sequencer for the DSP58-based FIR filter.
//  Each accepted input sample is written into a circular X buffer. The block then
//  issues one coefficient/sample read pair per tap, with first/last flags driving
//  the DSP58 accumulate mode. A DSP_LATENCY-delayed strobe marks the valid result.
//  Sits between the sample source and the coefficient ROM, X RAM and DSP58 MAC.
// PARAMETERS
//  H_ADDR_WIDTH  4  coefficient address width; max taps = 2**H_ADDR_WIDTH
//  X_ADDR_WIDTH  6  X buffer address width; 2**X_ADDR_WIDTH >= 2**H_ADDR_WIDTH required
//  DSP_LATENCY   4  DSP58 pipeline depth, in cycles from last read to result valid (>=1)
// PORTS
//  clk           in   1    system clock, rising edge
//  rst_n         in   1    asynchronous active-low reset
//  sample_valid  in   1    new input sample present this cycle
//  taps_m1       in   H_ADDR_WIDTH  tap count minus 1, latched at the WRITE cycle
//  W_en          out  1    X buffer write strobe
//  w_addr        out  X_ADDR_WIDTH  X buffer write address
//  R_en          out  1    coefficient ROM / X RAM read enable
//  h_addr        out  H_ADDR_WIDTH  coefficient read address
//  x_addr        out  X_ADDR_WIDTH  X buffer read address
//  first_tap     out  1    first MAC of the sample: DSP58 loads instead of accumulating
//  last_tap      out  1    final MAC of the sample
//  dsp58_delay   out  1    1-cycle pulse: DSP58 accumulator result is valid
//  filter_delay  out  1    busy: high in every state except IDLE
//  overrun       out  1    1-cycle pulse: sample_valid arrived while busy; sample dropped
// BEHAVIOUR
//  - All outputs are registered. Async reset: every output = 0, wr_ptr = 0, state = IDLE.
//  - FSM has four states: IDLE -> WRITE -> MAC -> DRAIN -> IDLE.
//  - IDLE: sample_valid=1 at cycle T moves the FSM to WRITE at T+1.
//  - WRITE (T+1, 1 cycle): W_en=1, w_addr=wr_ptr. Latch base=wr_ptr and n=taps_m1.
//    wr_ptr <= wr_ptr+1, wrapping modulo 2**X_ADDR_WIDTH.
//  - MAC (T+2 .. T+2+n): R_en=1. At tap k (k=0..n): h_addr=k, x_addr=(base-k) mod 2**X.
//    first_tap=1 only at k=0; last_tap=1 only at k=n. When n=0, both flags are set in
//    the single MAC cycle.
//  - DRAIN: DSP_LATENCY cycles with R_en=0. dsp58_delay=1 in the last DRAIN cycle,
//    i.e. exactly DSP_LATENCY cycles after last_tap. Next cycle is IDLE.
//  - filter_delay=1 from T+1 through the last DRAIN cycle. Min sample spacing = n+L+3
//    cycles, where L=DSP_LATENCY.
//  - sample_valid in WRITE/MAC/DRAIN: overrun=1 the following cycle. No state, wr_ptr
//    or address change. sample_valid in the IDLE cycle after DRAIN is accepted normally.
//  - R_en=0 outside MAC. In that case h_addr/x_addr hold their last values, and
//    first_tap/last_tap = 0.
//  - W_en=0 outside WRITE.
//  - taps_m1 changes outside WRITE have no effect on the sample in flight.
//  - Reset asserted mid-operation aborts immediately: outputs go to 0 and no
//    dsp58_delay pulse is issued. The first sample after reset writes address 0.
// TESTING
//  1 Reset: hold rst_n=0, then release -> all outputs 0, filter_delay=0, first W_en
//    has w_addr=0.
//  2 taps_m1=15, L=4, sample at T -> W_en@T+1 w_addr=0. R_en T+2..T+17 with
//    h_addr 0..15 and x_addr 0,63,62..49. first_tap@T+2, last_tap@T+17,
//    dsp58_delay@T+21, filter_delay low at T+22.
//  3 Wrap: wr_ptr=63, taps_m1=3 -> w_addr=63, x_addr 63,62,61,60. Next sample writes
//    w_addr=0 and reads x_addr 0,63,62,61.
//  4 taps_m1=0 -> one R_en cycle, first_tap=last_tap=1 together, dsp58_delay L cycles later.
//  5 Overrun: sample_valid during MAC -> overrun pulse next cycle, wr_ptr unchanged,
//    sequence completes unaltered. A sample at the first IDLE cycle is accepted.
//  6 Reset mid-MAC (k=5) -> outputs 0 asynchronously, no dsp58_delay. Next sample
//    uses w_addr=0 and h_addr starts at 0.

Source files
------------

// File: rtl/fir_addr_sequencer.sv
// Address/control sequencer for a DSP58 FIR: writes each sample into a circular
// X buffer, then walks coefficient/sample read pairs with first/last MAC flags.
module fir_addr_sequencer #(
    parameter int H_ADDR_WIDTH = 4,
    parameter int X_ADDR_WIDTH = 6,
    parameter int DSP_LATENCY  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_valid,
    input  logic [H_ADDR_WIDTH-1:0] taps_m1,
    output logic                    W_en,
    output logic [X_ADDR_WIDTH-1:0] w_addr,
    output logic                    R_en,
    output logic [H_ADDR_WIDTH-1:0] h_addr,
    output logic [X_ADDR_WIDTH-1:0] x_addr,
    output logic                    first_tap,
    output logic                    last_tap,
    output logic                    dsp58_delay,
    output logic                    filter_delay,
    output logic                    overrun
);

    localparam int CNT_W = (DSP_LATENCY > 1) ? $clog2(DSP_LATENCY) : 1;
    localparam logic [CNT_W-1:0]        DRAIN_LAST = CNT_W'(DSP_LATENCY - 1);
    localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
    localparam logic [H_ADDR_WIDTH-1:0] H_ONE      = H_ADDR_WIDTH'(1);
    localparam logic [X_ADDR_WIDTH-1:0] X_ONE      = X_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        MAC,
        DRAIN
    } state_t;

    state_t                  state;
    logic [X_ADDR_WIDTH-1:0] wr_ptr;
    logic [X_ADDR_WIDTH-1:0] base;
    logic [H_ADDR_WIDTH-1:0] n_taps;
    logic [CNT_W-1:0]        drain_cnt;

    // h_addr doubles as the tap index k; x_addr walks backwards from the newest sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            base         <= '0;
            n_taps       <= '0;
            drain_cnt    <= '0;
            W_en         <= 1'b0;
            w_addr       <= '0;
            R_en         <= 1'b0;
            h_addr       <= '0;
            x_addr       <= '0;
            first_tap    <= 1'b0;
            last_tap     <= 1'b0;
            dsp58_delay  <= 1'b0;
            filter_delay <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            W_en    <= 1'b0;
            overrun <= sample_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        state        <= WRITE;
                        W_en         <= 1'b1;
                        w_addr       <= wr_ptr;
                        base         <= wr_ptr;
                        filter_delay <= 1'b1;
                    end
                end
                WRITE: begin
                    state     <= MAC;
                    n_taps    <= taps_m1;
                    wr_ptr    <= wr_ptr + X_ONE;
                    R_en      <= 1'b1;
                    h_addr    <= '0;
                    x_addr    <= base;
                    first_tap <= 1'b1;
                    last_tap  <= (taps_m1 == '0);
                end
                MAC: begin
                    first_tap <= 1'b0;
                    if (h_addr == n_taps) begin
                        state       <= DRAIN;
                        R_en        <= 1'b0;
                        last_tap    <= 1'b0;
                        drain_cnt   <= '0;
                        dsp58_delay <= (DRAIN_LAST == '0);
                    end else begin
                        h_addr   <= h_addr + H_ONE;
                        x_addr   <= x_addr - X_ONE;
                        last_tap <= ((h_addr + H_ONE) == n_taps);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state        <= IDLE;
                        dsp58_delay  <= 1'b0;
                        filter_delay <= 1'b0;
                    end else begin
                        drain_cnt   <= drain_cnt + CNT_ONE;
                        dsp58_delay <= ((drain_cnt + CNT_ONE) == DRAIN_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_addr_sequencer.sv
// Bench for fir_addr_sequencer: directed and random samples checked every cycle
// against a per-sample timeline model derived from the accept cycle.
module tb_fir_addr_sequencer;

    localparam int H       = 4;
    localparam int X       = 6;
    localparam int L       = 4;
    localparam int X_DEPTH = 1 << X;

    logic         clk          = 1'b0;
    logic         rst_n        = 1'b1;
    logic         sample_valid = 1'b0;
    logic [H-1:0] taps_m1      = '0;
    logic         W_en;
    logic [X-1:0] w_addr;
    logic         R_en;
    logic [H-1:0] h_addr;
    logic [X-1:0] x_addr;
    logic         first_tap;
    logic         last_tap;
    logic         dsp58_delay;
    logic         filter_delay;
    logic         overrun;

    int errors = 0;
    int checks = 0;

    // Reference model: one in-flight sample described by its accept cycle t0.
    int cyc     = 0;
    int t0      = 0;
    int n_m     = 0;
    int base_m  = 0;
    int wrp_m   = 0;
    int waddr_m = 0;
    int h_m     = 0;
    int x_m     = 0;
    bit have_job = 1'b0;
    bit ovr_m    = 1'b0;

    fir_addr_sequencer #(
        .H_ADDR_WIDTH(H),
        .X_ADDR_WIDTH(X),
        .DSP_LATENCY (L)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_valid(sample_valid),
        .taps_m1     (taps_m1),
        .W_en        (W_en),
        .w_addr      (w_addr),
        .R_en        (R_en),
        .h_addr      (h_addr),
        .x_addr      (x_addr),
        .first_tap   (first_tap),
        .last_tap    (last_tap),
        .dsp58_delay (dsp58_delay),
        .filter_delay(filter_delay),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit nextBusy();
        int d;
        d = cyc + 1 - t0;
        return have_job && (d >= 1) && (d <= 2 + n_m + L);
    endfunction

    // One clock cycle: check outputs against the model, then drive this cycle's inputs.
    task automatic applyStimulus(input bit sv, input logic [H-1:0] taps);
        int d;
        bit e_wen, e_ren, e_first, e_last, e_dsp, e_busy;
        @(negedge clk);
        cyc++;
        d       = cyc - t0;
        e_wen   = have_job && (d == 1);
        e_ren   = have_job && (d >= 2) && (d <= 2 + n_m);
        if (e_ren) begin
            h_m = d - 2;
            x_m = ((base_m - (d - 2)) % X_DEPTH + X_DEPTH) % X_DEPTH;
        end
        e_first = e_ren && (d == 2);
        e_last  = e_ren && (d == 2 + n_m);
        e_dsp   = have_job && (d == 2 + n_m + L);
        e_busy  = have_job && (d >= 1) && (d <= 2 + n_m + L);
        checkOutput("W_en", 32'(W_en), 32'(e_wen));
        checkOutput("w_addr", 32'(w_addr), 32'(waddr_m));
        checkOutput("R_en", 32'(R_en), 32'(e_ren));
        checkOutput("h_addr", 32'(h_addr), 32'(h_m));
        checkOutput("x_addr", 32'(x_addr), 32'(x_m));
        checkOutput("first_tap", 32'(first_tap), 32'(e_first));
        checkOutput("last_tap", 32'(last_tap), 32'(e_last));
        checkOutput("dsp58_delay", 32'(dsp58_delay), 32'(e_dsp));
        checkOutput("filter_delay", 32'(filter_delay), 32'(e_busy));
        checkOutput("overrun", 32'(overrun), 32'(ovr_m));

        if (have_job && d == 1) n_m = int'(taps);
        sample_valid = sv;
        taps_m1      = taps;
        ovr_m        = sv && e_busy;
        if (sv && !e_busy) begin
            have_job = 1'b1;
            t0       = cyc;
            n_m      = 0;
            base_m   = wrp_m;
            waddr_m  = wrp_m;
            wrp_m    = (wrp_m + 1) % X_DEPTH;
        end
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_W_en", 32'(W_en), 32'd0);
        checkOutput("rst_w_addr", 32'(w_addr), 32'd0);
        checkOutput("rst_R_en", 32'(R_en), 32'd0);
        checkOutput("rst_h_addr", 32'(h_addr), 32'd0);
        checkOutput("rst_x_addr", 32'(x_addr), 32'd0);
        checkOutput("rst_first_tap", 32'(first_tap), 32'd0);
        checkOutput("rst_last_tap", 32'(last_tap), 32'd0);
        checkOutput("rst_dsp58_delay", 32'(dsp58_delay), 32'd0);
        checkOutput("rst_filter_delay", 32'(filter_delay), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        sample_valid = 1'b0;
        have_job     = 1'b0;
        ovr_m        = 1'b0;
        wrp_m        = 0;
        waddr_m      = 0;
        h_m          = 0;
        x_m          = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 64 && nextBusy(); i++) applyStimulus(1'b0, H'($urandom));
    endtask

    initial begin
        #1;
        applyReset();

        // Full 16-tap sample straight after reset: writes address 0.
        applyStimulus(1'b1, 4'd15);
        applyStimulus(1'b0, 4'd15);
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, H'($urandom));

        // Continuous requests with a single tap until the write pointer sits at 63.
        for (int i = 0; i < 2000 && !(wrp_m == X_DEPTH - 1 && !nextBusy()); i++)
            applyStimulus(1'b1, 4'd0);
        waitIdle();
        applyStimulus(1'b1, 4'd3);
        applyStimulus(1'b0, 4'd3);
        waitIdle();
        applyStimulus(1'b1, 4'd3);
        applyStimulus(1'b0, 4'd3);
        waitIdle();

        // Single-tap sample: first and last flags coincide.
        applyStimulus(1'b1, 4'd0);
        applyStimulus(1'b0, 4'd0);
        waitIdle();

        // Overrun during MAC, then a sample on the first IDLE cycle.
        applyStimulus(1'b1, 4'd15);
        applyStimulus(1'b0, 4'd15);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, H'($urandom));
        applyStimulus(1'b1, H'($urandom));
        waitIdle();
        applyStimulus(1'b1, 4'd2);
        applyStimulus(1'b0, 4'd2);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, H'($urandom));
        applyStimulus(1'b1, H'($urandom));
        applyStimulus(1'b1, 4'd5);
        applyStimulus(1'b0, 4'd5);
        waitIdle();

        // Reset while the sequencer shows tap k=5.
        applyStimulus(1'b1, 4'd15);
        applyStimulus(1'b0, 4'd15);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, H'($urandom));
        #2;
        applyReset();
        applyStimulus(1'b1, 4'd7);
        applyStimulus(1'b0, 4'd7);
        waitIdle();

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 6) == 0, H'($urandom));
            if (($urandom % 500) == 0) begin
                #2;
                applyReset();
            end
        end
        waitIdle();
        applyStimulus(1'b0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
